// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, prescale floor and legal
// data-width range (also used by the receive engine).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5,
        ST_BREAK  = 3'd6
    } uart_state_e;

    localparam int MIN_PRESCALE = 2;
    localparam int DATA_W_MIN   = 5;
    localparam int DATA_W_MAX   = 9;

    // True when a data width lies inside the supported frame range.
    function automatic bit data_w_legal(input int w);
        return (w >= DATA_W_MIN) && (w <= DATA_W_MAX);
    endfunction

endpackage

// File: rtl/uart_tx_engine_baud_gen.sv
// Bit-time generator: loadable down-counter that produces a one-clock
// bit_tick on the last clock of every bit and bit_last one clock earlier.
// The reload value is captured on the frame-start strobe.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] period_m1,
    output logic                  bit_tick,
    output logic                  bit_last
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [PRESCALE_W-1:0] reload_q, reload_d;

    // Restart on the frame strobe, otherwise count down and reload at zero.
    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        if (load) begin
            cnt_d    = period_m1;
            reload_d = period_m1;
        end else if (en) begin
            if (cnt_q == '0) begin
                cnt_d = reload_q;
            end else begin
                cnt_d = cnt_q - PRESCALE_W'(1);
            end
        end
    end

    // Counter registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            reload_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
        end
    end

    assign bit_tick = en && (cnt_q == '0);
    assign bit_last = en && (cnt_q == PRESCALE_W'(1));

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: prescaled bit timing, DATA_W-bit LSB-first
// serializer, optional even/odd parity, one or two stop bits.
// Define UART_TX_BREAK_EN to build the line-break generator.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_odd,
    input  logic                  stop2,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic                  break_req,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int                BCNT_W   = 4;
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);
`ifdef UART_TX_BREAK_EN
    localparam logic [BCNT_W-1:0] BRK_BITS = BCNT_W'(DATA_W + 2);
`endif

    uart_state_e           state_q, state_d;
    logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_en_q, par_en_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_out_q, tx_out_d;
    logic                  busy_q, busy_d;
    logic                  tx_done_q, tx_done_d;

    logic                  frame_start;
    logic                  accept;
    logic                  bit_tick;
    logic                  bit_last;
    logic [PRESCALE_W-1:0] psc_m1;

    // Prescale values below the floor run at the floor rate.
    assign psc_m1 = (prescale < PRESCALE_W'(MIN_PRESCALE)) ?
                    PRESCALE_W'(MIN_PRESCALE - 1) : (prescale - PRESCALE_W'(1));

    assign data_ready = (state_q == ST_IDLE);

`ifdef UART_TX_BREAK_EN
    assign accept = data_valid && data_ready && !break_req;
`else
    logic unused_break_req;
    assign unused_break_req = break_req;
    assign accept = data_valid && data_ready;
`endif

    uart_baud_gen #(
        .PRESCALE_W (PRESCALE_W)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .load      (frame_start),
        .en        (busy_q),
        .period_m1 (psc_m1),
        .bit_tick  (bit_tick),
        .bit_last  (bit_last)
    );

    // Frame sequencing, payload capture and registered output decode.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        par_en_d    = par_en_q;
        stop2_d     = stop2_q;
        tx_done_d   = 1'b0;
        frame_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                    state_d     = ST_BREAK;
                    bit_cnt_d   = '0;
                    frame_start = 1'b1;
                end
`endif
                if (accept) begin
                    state_d     = ST_START;
                    shift_d     = data_in;
                    par_bit_d   = (^data_in) ^ par_odd;
                    par_en_d    = par_en;
                    stop2_d     = stop2;
                    bit_cnt_d   = '0;
                    frame_start = 1'b1;
                end
            end
            ST_START: begin
                if (bit_tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) state_d = ST_STOP1;
            end
            ST_STOP1: begin
                if (!stop2_q && bit_last) tx_done_d = 1'b1;
                if (bit_tick) state_d = stop2_q ? ST_STOP2 : ST_IDLE;
            end
            ST_STOP2: begin
                if (bit_last) tx_done_d = 1'b1;
                if (bit_tick) state_d = ST_IDLE;
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                if (bit_tick && (bit_cnt_q != BRK_BITS)) begin
                    bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                end
                if (!break_req && ((bit_cnt_q == BRK_BITS) ||
                                   (bit_tick && (bit_cnt_q == BRK_BITS - BCNT_W'(1))))) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START:  tx_out_d = 1'b0;
            ST_BREAK:  tx_out_d = 1'b0;
            ST_DATA:   tx_out_d = shift_d[0];
            ST_PARITY: tx_out_d = par_bit_q;
            default:   tx_out_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
            tx_done_q <= tx_done_d;
        end
    end

    // Payload shift register and parity bit; only meaningful inside a frame.
    always_ff @(posedge clk) begin
        shift_q   <= shift_d;
        par_bit_q <= par_bit_d;
    end

    assign tx_out  = tx_out_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: table of frames with hand-written
// serial waveforms, plus back-to-back, mid-frame reset and break sequences.
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] prescale;
    logic        par_en, par_odd, stop2;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic        break_req;
    logic        tx_out, busy, tx_done;

    int nchk = 0;
    int nerr = 0;

    uart_tx_engine #(
        .DATA_W     (8),
        .PRESCALE_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_odd    (par_odd),
        .stop2      (stop2),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .break_req  (break_req),
        .tx_out     (tx_out),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    // seq holds the serial bits in time order, first bit in seq[11].
    typedef struct {
        logic [15:0] psc;
        logic        pe;
        logic        po;
        logic        s2;
        logic [7:0]  data;
        int          nbits;
        int          p;
        logic [11:0] seq;
        logic        brk_mid;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((data_ready !== 1'b1) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(n < 200), 32'd1);
    endtask

    // Outputs compared as {tx_out, busy, data_ready, tx_done}.
    task automatic run_frame(input vec_t v, input string name);
        int np;
        logic [3:0] exp;
        np = v.nbits * v.p;
        wait_idle();
        @(negedge clk);
        prescale   = v.psc;
        par_en     = v.pe;
        par_odd    = v.po;
        stop2      = v.s2;
        data_in    = v.data;
        data_valid = 1'b1;
        for (int c = 1; c <= np + 1; c++) begin
            @(negedge clk);
            if (c <= np) exp = {v.seq[11 - (c - 1) / v.p], 1'b1, 1'b0, (c == np)};
            else         exp = 4'b1010;
            check(name, {tx_out, busy, data_ready, tx_done}, exp);
            if (c == 1) begin
                data_valid = 1'b0;
                data_in    = ~v.data;
                prescale   = 16'd7;
                par_en     = ~v.pe;
                par_odd    = ~v.po;
                stop2      = ~v.s2;
                if (v.brk_mid) break_req = 1'b1;
            end
            if ((c == np) && v.brk_mid) break_req = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [3:0]  exp;
        logic [11:0] s_a, s_b;

        vecs[0] = '{16'd4, 1'b0, 1'b0, 1'b0, 8'hA5, 10, 4, 12'b0101_0010_1100, 1'b0};
        vecs[1] = '{16'd3, 1'b1, 1'b0, 1'b1, 8'h07, 12, 3, 12'b0111_0000_0111, 1'b1};
        vecs[2] = '{16'd2, 1'b1, 1'b1, 1'b0, 8'h00, 11, 2, 12'b0000_0000_0110, 1'b0};
        vecs[3] = '{16'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 10, 2, 12'b0111_1111_1100, 1'b0};
        vecs[4] = '{16'd1, 1'b1, 1'b0, 1'b0, 8'h5A, 11, 2, 12'b0010_1101_0010, 1'b0};

        rst        = 1'b0;
        prescale   = 16'd4;
        par_en     = 1'b0;
        par_odd    = 1'b0;
        stop2      = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        break_req  = 1'b0;

        #12;
        check("reset_state", {tx_out, busy, data_ready, tx_done}, 4'b1010);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {tx_out, busy, data_ready, tx_done}, 4'b1010);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], $sformatf("frame%0d", i));
        end

        // Back-to-back frames with data_valid held high.
        s_a = 12'b0001_1110_0100;
        s_b = 12'b0110_0001_1100;
        wait_idle();
        @(negedge clk);
        prescale   = 16'd2;
        par_en     = 1'b0;
        stop2      = 1'b0;
        data_in    = 8'h3C;
        data_valid = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            if (c <= 20)      exp = {s_a[11 - (c - 1) / 2], 1'b1, 1'b0, (c == 20)};
            else if (c == 21) exp = 4'b1010;
            else if (c <= 41) exp = {s_b[11 - (c - 22) / 2], 1'b1, 1'b0, (c == 41)};
            else              exp = 4'b1010;
            check("back_to_back", {tx_out, busy, data_ready, tx_done}, exp);
            if (c == 1)  data_in = 8'hC3;
            if (c == 22) data_valid = 1'b0;
        end

        // Reset asserted during data bit 3 of an 8N1 frame.
        wait_idle();
        @(negedge clk);
        prescale   = 16'd4;
        par_en     = 1'b0;
        stop2      = 1'b0;
        data_in    = 8'hA5;
        data_valid = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) data_valid = 1'b0;
        end
        check("pre_reset_bit3", {tx_out, busy, data_ready}, 3'b010);
        rst = 1'b0;
        #1;
        check("reset_midframe", {tx_out, busy, data_ready, tx_done}, 4'b1010);
        @(negedge clk);
        rst = 1'b1;
        run_frame(vecs[0], "frame_after_reset");

`ifdef UART_TX_BREAK_EN
        // Break for two bit-times with a payload waiting.
        wait_idle();
        @(negedge clk);
        prescale   = 16'd4;
        par_en     = 1'b0;
        stop2      = 1'b0;
        data_in    = 8'h3C;
        data_valid = 1'b1;
        break_req  = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            if (c <= 40)      exp = 4'b0100;
            else if (c == 41) exp = 4'b1010;
            else              exp = 4'b0100;
            check("break", {tx_out, busy, data_ready, tx_done}, exp);
            if (c == 8)  break_req = 1'b0;
            if (c == 42) data_valid = 1'b0;
        end
        wait_idle();
`else
        // Without the break generator, break_req has no effect.
        break_req = 1'b1;
        run_frame(vecs[0], "break_ignored");
        break_req = 1'b0;
`endif

        wait_idle();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
